// File: rtl/mem_port_arbiter_pkg.sv
// rtl/mem_port_arbiter_pkg.sv - shared types for the two-requester memory port arbiter
// Width macros fall back to 32-bit address/data and an 8-bit burstcount when not given.
`ifndef MEM_ADDR_W
`define MEM_ADDR_W 32
`endif
`ifndef MEM_DATA_W
`define MEM_DATA_W 32
`endif
`ifndef MEM_BURST_CNT_W
`define MEM_BURST_CNT_W 8
`endif

package mem_port_arbiter_pkg;

   localparam int BURST_W = `MEM_BURST_CNT_W;

   typedef logic req_id_t;

   typedef enum logic {
      IDLE     = 1'b0,
      WR_BURST = 1'b1
   } arb_state_t;

   typedef struct packed {
      req_id_t            id;
      logic [BURST_W-1:0] burstcount;
   } rd_entry_t;

endpackage

// File: rtl/mem_port_arb_rd_tracker.sv
// rtl/mem_port_arb_rd_tracker.sv - FIFO of outstanding reads {id, burstcount}
// A pop and a push in the same cycle are legal when full: the pop frees the slot first.
module mem_port_arb_rd_tracker
   import mem_port_arbiter_pkg::*;
#(
   parameter int LOG_ELS = 4
)(
   input  logic      clk,
   input  logic      rst,
   input  logic      push,
   input  rd_entry_t push_entry,
   input  logic      pop,
   output logic      full,
   output logic      empty,
   output rd_entry_t head
);

   localparam int DEPTH = 1 << LOG_ELS;

   rd_entry_t            entries [DEPTH];
   logic [LOG_ELS-1:0]   wr_ptr;
   logic [LOG_ELS-1:0]   rd_ptr;
   logic [LOG_ELS:0]     count;
   logic                 do_push;
   logic                 do_pop;

   assign empty   = (count == '0);
   assign full    = (count == (LOG_ELS+1)'(DEPTH));
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);
   assign head    = empty ? '0 : entries[rd_ptr];

   always_ff @(posedge clk) begin
      if (do_push) entries[wr_ptr] <= push_entry;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - round-robin sharing of one Avalon-style memory port by two requesters
// Optional saturating grant/stall counters: define MEM_PORT_ARBITER_STATS_EN.
`ifndef MEM_ADDR_W
`define MEM_ADDR_W 32
`endif
`ifndef MEM_DATA_W
`define MEM_DATA_W 32
`endif
`ifndef MEM_BURST_CNT_W
`define MEM_BURST_CNT_W 8
`endif

module mem_port_arbiter
   import mem_port_arbiter_pkg::*;
#(
   parameter int MEM_ADDR_W       = `MEM_ADDR_W,
   parameter int MEM_DATA_W       = `MEM_DATA_W,
   parameter int MEM_BURST_CNT_W  = `MEM_BURST_CNT_W,
   parameter int RD_TRACK_LOG_ELS = 4
)(
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       req0_read_in,
   input  logic                       req0_write_in,
   input  logic [MEM_ADDR_W-1:0]      req0_address_in,
   input  logic [MEM_DATA_W-1:0]      req0_writedata_in,
   input  logic [MEM_BURST_CNT_W-1:0] req0_burstcount_in,
   input  logic [MEM_DATA_W/8-1:0]    req0_byteenable_in,
   output logic                       req0_ready_out,
   output logic [MEM_DATA_W-1:0]      req0_readdata_out,
   output logic                       req0_readdatavalid_out,
   input  logic                       req1_read_in,
   input  logic                       req1_write_in,
   input  logic [MEM_ADDR_W-1:0]      req1_address_in,
   input  logic [MEM_DATA_W-1:0]      req1_writedata_in,
   input  logic [MEM_BURST_CNT_W-1:0] req1_burstcount_in,
   input  logic [MEM_DATA_W/8-1:0]    req1_byteenable_in,
   output logic                       req1_ready_out,
   output logic [MEM_DATA_W-1:0]      req1_readdata_out,
   output logic                       req1_readdatavalid_out,
   input  logic                       mem_ready_in,
   output logic                       mem_read_out,
   output logic                       mem_write_out,
   output logic [MEM_ADDR_W-1:0]      mem_address_out,
   output logic [MEM_DATA_W-1:0]      mem_writedata_out,
   output logic [MEM_BURST_CNT_W-1:0] mem_burstcount_out,
   output logic [MEM_DATA_W/8-1:0]    mem_byteenable_out,
   input  logic [MEM_DATA_W-1:0]      mem_readdata_in,
   input  logic                       mem_readdatavalid_in,
   output logic                       rd_err_out
`ifdef MEM_PORT_ARBITER_STATS_EN
   ,
   output logic [31:0]                stats_grant_cnt_out [2],
   output logic [31:0]                stats_stall_cnt_out [2]
`endif
);

   logic [1:0]                 rd_req, wr_req, req_any, ready, rdv;
   logic [MEM_ADDR_W-1:0]      addr  [2];
   logic [MEM_DATA_W-1:0]      wdata [2];
   logic [MEM_BURST_CNT_W-1:0] bcnt  [2];
   logic [MEM_DATA_W/8-1:0]    ben   [2];

   arb_state_t                 state, state_nxt;
   req_id_t                    prio, owner, grant;
   logic [MEM_BURST_CNT_W-1:0] beats_left, hold_bcnt;
   logic [MEM_ADDR_W-1:0]      hold_addr;
   logic [BURST_W-1:0]         beat_cnt;
   logic                       rd_err, rd_cmd, wr_cmd, accept, burst_start, burst_last;
   logic                       trk_full, trk_empty, trk_push, trk_pop, trk_room, ret_valid;
   rd_entry_t                  trk_head, trk_entry;

   assign rd_req  = {req1_read_in,  req0_read_in};
   assign wr_req  = {req1_write_in, req0_write_in};
   assign req_any = rd_req | wr_req;
   assign addr[0]  = req0_address_in;    assign addr[1]  = req1_address_in;
   assign wdata[0] = req0_writedata_in;  assign wdata[1] = req1_writedata_in;
   assign bcnt[0]  = req0_burstcount_in; assign bcnt[1]  = req1_burstcount_in;
   assign ben[0]   = req0_byteenable_in; assign ben[1]   = req1_byteenable_in;

   // Read returns: a full tracker still has room when its head retires this cycle.
   assign ret_valid = mem_readdatavalid_in && !trk_empty;
   assign trk_pop   = ret_valid && ((trk_head.burstcount <= BURST_W'(1)) ||
                                    (beat_cnt == trk_head.burstcount - 1'b1));
   assign trk_room  = !trk_full || trk_pop;
   assign trk_push  = accept && rd_cmd;
   assign trk_entry = '{id: grant, burstcount: BURST_W'(bcnt[grant])};
   assign rdv       = {ret_valid && (trk_head.id == 1'b1), ret_valid && (trk_head.id == 1'b0)};

   assign burst_start = accept && wr_cmd && (state == IDLE) &&
                        (bcnt[grant] > MEM_BURST_CNT_W'(1));
   assign burst_last  = accept && (state == WR_BURST) &&
                        (beats_left <= MEM_BURST_CNT_W'(1));

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= IDLE;
      else      state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:     if (burst_start) state_nxt = WR_BURST;
         WR_BURST: if (burst_last)  state_nxt = IDLE;
         default:  state_nxt = IDLE;
      endcase
   end

   always_comb begin
      grant = prio;
      if (state == WR_BURST)                        grant = owner;
      else if (!req_any[prio] && req_any[~prio])    grant = ~prio;
      rd_cmd = (state == IDLE) && rd_req[grant] && trk_room;
      wr_cmd = wr_req[grant] && !((state == IDLE) && rd_req[grant]);
      accept = rst && mem_ready_in && (rd_cmd || wr_cmd);
      ready        = '0;
      ready[grant] = accept;
      mem_read_out       = rst && rd_cmd;
      mem_write_out      = rst && wr_cmd;
      mem_address_out    = '0;
      mem_writedata_out  = '0;
      mem_burstcount_out = '0;
      mem_byteenable_out = '0;
      if (rst) begin
         mem_address_out    = (state == WR_BURST) ? hold_addr : addr[grant];
         mem_burstcount_out = (state == WR_BURST) ? hold_bcnt : bcnt[grant];
         mem_writedata_out  = wdata[grant];
         mem_byteenable_out = ben[grant];
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         prio       <= 1'b0;
         owner      <= 1'b0;
         beats_left <= '0;
         hold_addr  <= '0;
         hold_bcnt  <= '0;
         beat_cnt   <= '0;
         rd_err     <= 1'b0;
      end else begin
         if (accept) begin
            if (state == IDLE) begin
               if (burst_start) begin
                  owner      <= grant;
                  beats_left <= bcnt[grant] - 1'b1;
                  hold_addr  <= addr[grant];
                  hold_bcnt  <= bcnt[grant];
               end else begin
                  prio <= ~grant;
               end
            end else begin
               beats_left <= beats_left - 1'b1;
               if (burst_last) prio <= ~owner;
            end
         end
         if (ret_valid) beat_cnt <= trk_pop ? '0 : beat_cnt + 1'b1;
         if (mem_readdatavalid_in && trk_empty) rd_err <= 1'b1;
      end
   end

   mem_port_arb_rd_tracker #(.LOG_ELS(RD_TRACK_LOG_ELS)) u_rd_tracker (
      .clk        (clk),
      .rst        (rst),
      .push       (trk_push),
      .push_entry (trk_entry),
      .pop        (trk_pop),
      .full       (trk_full),
      .empty      (trk_empty),
      .head       (trk_head)
   );

   assign req0_ready_out         = ready[0];
   assign req1_ready_out         = ready[1];
   assign req0_readdatavalid_out = rst && rdv[0];
   assign req1_readdatavalid_out = rst && rdv[1];
   assign req0_readdata_out      = rst ? mem_readdata_in : '0;
   assign req1_readdata_out      = rst ? mem_readdata_in : '0;
   assign rd_err_out             = rd_err;

`ifdef MEM_PORT_ARBITER_STATS_EN
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < 2; i++) begin
            stats_grant_cnt_out[i] <= '0;
            stats_stall_cnt_out[i] <= '0;
         end
      end else begin
         for (int i = 0; i < 2; i++) begin
            if (ready[i] && (state == IDLE) && (stats_grant_cnt_out[i] != '1))
               stats_grant_cnt_out[i] <= stats_grant_cnt_out[i] + 1'b1;
            if (req_any[i] && !ready[i] && (stats_stall_cnt_out[i] != '1))
               stats_stall_cnt_out[i] <= stats_stall_cnt_out[i] + 1'b1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - directed scoreboard bench for mem_port_arbiter
// Expected read-return routing is queued when a read is accepted and checked as beats come back.
module tb_mem_port_arbiter;

   localparam int AW = 32;
   localparam int DW = 32;
   localparam int BW = 8;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          req0_read_in = 0, req0_write_in = 0, req1_read_in = 0, req1_write_in = 0;
   logic [AW-1:0] req0_address_in = '0, req1_address_in = '0;
   logic [DW-1:0] req0_writedata_in = '0, req1_writedata_in = '0;
   logic [BW-1:0] req0_burstcount_in = 8'd1, req1_burstcount_in = 8'd1;
   logic [3:0]    req0_byteenable_in = 4'hf, req1_byteenable_in = 4'hf;
   logic          req0_ready_out, req1_ready_out, req0_readdatavalid_out, req1_readdatavalid_out;
   logic [DW-1:0] req0_readdata_out, req1_readdata_out;
   logic          mem_ready_in = 1'b0, mem_readdatavalid_in = 1'b0;
   logic [DW-1:0] mem_readdata_in = '0;
   logic          mem_read_out, mem_write_out, rd_err_out;
   logic [AW-1:0] mem_address_out;
   logic [DW-1:0] mem_writedata_out;
   logic [BW-1:0] mem_burstcount_out;
   logic [3:0]    mem_byteenable_out;
`ifdef MEM_PORT_ARBITER_STATS_EN
   logic [31:0]   stats_grant_cnt [2];
   logic [31:0]   stats_stall_cnt [2];
`endif

   typedef struct {
      logic          id;
      logic [DW-1:0] data;
   } exp_t;

   exp_t sb[$];
   int   vec_cnt = 0;
   int   err_cnt = 0;

   always #5 clk = ~clk;

   mem_port_arbiter #(
      .MEM_ADDR_W(AW), .MEM_DATA_W(DW), .MEM_BURST_CNT_W(BW), .RD_TRACK_LOG_ELS(2)
   ) dut (
      .clk(clk), .rst(rst),
      .req0_read_in(req0_read_in), .req0_write_in(req0_write_in),
      .req0_address_in(req0_address_in), .req0_writedata_in(req0_writedata_in),
      .req0_burstcount_in(req0_burstcount_in), .req0_byteenable_in(req0_byteenable_in),
      .req0_ready_out(req0_ready_out), .req0_readdata_out(req0_readdata_out),
      .req0_readdatavalid_out(req0_readdatavalid_out),
      .req1_read_in(req1_read_in), .req1_write_in(req1_write_in),
      .req1_address_in(req1_address_in), .req1_writedata_in(req1_writedata_in),
      .req1_burstcount_in(req1_burstcount_in), .req1_byteenable_in(req1_byteenable_in),
      .req1_ready_out(req1_ready_out), .req1_readdata_out(req1_readdata_out),
      .req1_readdatavalid_out(req1_readdatavalid_out),
      .mem_ready_in(mem_ready_in), .mem_read_out(mem_read_out), .mem_write_out(mem_write_out),
      .mem_address_out(mem_address_out), .mem_writedata_out(mem_writedata_out),
      .mem_burstcount_out(mem_burstcount_out), .mem_byteenable_out(mem_byteenable_out),
      .mem_readdata_in(mem_readdata_in), .mem_readdatavalid_in(mem_readdatavalid_in),
      .rd_err_out(rd_err_out)
`ifdef MEM_PORT_ARBITER_STATS_EN
      , .stats_grant_cnt_out(stats_grant_cnt), .stats_stall_cnt_out(stats_stall_cnt)
`endif
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vec_cnt++;
      assert (obs === exp) else begin
         err_cnt++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #1;
   endtask

   task automatic issue_read(input int n, input logic [AW-1:0] a, input logic [BW-1:0] bc,
                             input logic [DW-1:0] base);
      exp_t e;
      if (n == 0) begin
         req0_read_in = 1'b1; req0_address_in = a; req0_burstcount_in = bc;
      end else begin
         req1_read_in = 1'b1; req1_address_in = a; req1_burstcount_in = bc;
      end
      settle();
      check($sformatf("read_ready_req%0d", n), (n == 0) ? req0_ready_out : req1_ready_out, 1);
      check($sformatf("read_addr_req%0d", n), mem_address_out, a);
      for (int k = 0; k < int'(bc); k++) begin
         e.id   = (n == 1);
         e.data = base + DW'(k);
         sb.push_back(e);
      end
      tick();
      req0_read_in = 1'b0;
      req1_read_in = 1'b0;
   endtask

   task automatic ret_beat();
      exp_t e;
      if (sb.size() == 0) begin
         check("scoreboard_nonempty", 0, 1);
      end else begin
         e = sb.pop_front();
         mem_readdatavalid_in = 1'b1;
         mem_readdata_in      = e.data;
         settle();
         check("ret_valid_req0", req0_readdatavalid_out, (e.id == 1'b0));
         check("ret_valid_req1", req1_readdatavalid_out, (e.id == 1'b1));
         check("ret_data", e.id ? req1_readdata_out : req0_readdata_out, e.data);
      end
   endtask

   task automatic ret_end();
      tick();
      mem_readdatavalid_in = 1'b0;
   endtask

   task automatic drain(input int n);
      for (int k = 0; k < n; k++) begin
         ret_beat();
         ret_end();
      end
   endtask

   initial begin
      // Reset: outputs forced low even with requests present
      req0_read_in = 1'b1;
      mem_ready_in = 1'b1;
      tick();
      check("rst_ready0", req0_ready_out, 0);
      check("rst_mem_read", mem_read_out, 0);
      check("rst_mem_write", mem_write_out, 0);
      check("rst_rd_err", rd_err_out, 0);
      req0_read_in = 1'b0;
      rst = 1'b1;
      tick();

      // Simultaneous reads: req0 first, req1 next cycle, returns routed in order
      req0_read_in = 1'b1; req0_address_in = 32'h100; req0_burstcount_in = 8'd1;
      req1_read_in = 1'b1; req1_address_in = 32'h200; req1_burstcount_in = 8'd1;
      settle();
      check("rr_c0_ready0", req0_ready_out, 1);
      check("rr_c0_ready1", req1_ready_out, 0);
      check("rr_c0_addr", mem_address_out, 32'h100);
      sb.push_back('{id: 1'b0, data: 32'hD000_0000});
      tick();
      req0_read_in = 1'b0;
      settle();
      check("rr_c1_ready1", req1_ready_out, 1);
      check("rr_c1_addr", mem_address_out, 32'h200);
      sb.push_back('{id: 1'b1, data: 32'hD000_0001});
      tick();
      req1_read_in = 1'b0;
      settle();
      check("idle_no_read", mem_read_out, 0);
      check("idle_no_write", mem_write_out, 0);
      drain(2);

      // Multi-beat reads: 3 beats to req0, then 2 to req1
      issue_read(0, 32'h300, 8'd3, 32'hA300_0000);
      issue_read(1, 32'h400, 8'd2, 32'hA400_0000);
      drain(5);

      // req1 4-beat write locks out req0 reads; one owner stall in the middle
      req1_write_in = 1'b1; req1_address_in = 32'h500; req1_burstcount_in = 8'd4;
      req1_writedata_in = 32'hB000_0000;
      settle();
      check("wb_b0_ready1", req1_ready_out, 1);
      check("wb_b0_write", mem_write_out, 1);
      check("wb_b0_bcnt", mem_burstcount_out, 4);
      tick();
      req0_read_in = 1'b1; req0_address_in = 32'h600; req0_burstcount_in = 8'd1;
      req1_address_in = 32'hDEAD; req1_burstcount_in = 8'd1;
      for (int b = 1; b < 4; b++) begin
         if (b == 2) begin
            req1_write_in = 1'b0;
            settle();
            check("wb_stall_ready1", req1_ready_out, 0);
            check("wb_stall_ready0", req0_ready_out, 0);
            check("wb_stall_cmd", {mem_read_out, mem_write_out}, 0);
            tick();
            req1_write_in = 1'b1;
         end
         req1_writedata_in = 32'hB000_0000 + DW'(b);
         settle();
         check($sformatf("wb_b%0d_ready0", b), req0_ready_out, 0);
         check($sformatf("wb_b%0d_ready1", b), req1_ready_out, 1);
         check($sformatf("wb_b%0d_bcnt", b), mem_burstcount_out, 4);
         check($sformatf("wb_b%0d_addr", b), mem_address_out, 32'h500);
         check($sformatf("wb_b%0d_wdata", b), mem_writedata_out, 32'hB000_0000 + b);
         tick();
      end
      req1_write_in = 1'b0;
      settle();
      check("wb_after_ready0", req0_ready_out, 1);
      sb.push_back('{id: 1'b0, data: 32'hA600_0000});
      tick();
      req0_read_in = 1'b0;
      drain(1);

      // Tracker of 4: fifth read waits for the head's last beat, accepted that cycle
      issue_read(0, 32'h700, 8'd2, 32'hA700_0000);
      issue_read(1, 32'h710, 8'd1, 32'hA710_0000);
      issue_read(0, 32'h720, 8'd1, 32'hA720_0000);
      issue_read(1, 32'h730, 8'd1, 32'hA730_0000);
      req0_read_in = 1'b1; req0_address_in = 32'h740; req0_burstcount_in = 8'd1;
      settle();
      check("full_ready0", req0_ready_out, 0);
      check("full_mem_read", mem_read_out, 0);
      ret_beat();
      check("full_first_beat_ready0", req0_ready_out, 0);
      ret_end();
      ret_beat();
      check("full_last_beat_ready0", req0_ready_out, 1);
      check("full_last_beat_mem_read", mem_read_out, 1);
      sb.push_back('{id: 1'b0, data: 32'hA740_0000});
      ret_end();
      req0_read_in = 1'b0;
      drain(4);

      // Stray return with nothing outstanding
      check("err_before", rd_err_out, 0);
      mem_readdatavalid_in = 1'b1;
      mem_readdata_in      = 32'hEEEE_EEEE;
      settle();
      check("err_drop_v0", req0_readdatavalid_out, 0);
      check("err_drop_v1", req1_readdatavalid_out, 0);
      ret_end();
      check("err_set", rd_err_out, 1);
      repeat (3) tick();
      check("err_sticky", rd_err_out, 1);

      // Reset during the second beat of a 4-beat write
      req0_write_in = 1'b1; req0_address_in = 32'h800; req0_burstcount_in = 8'd4;
      settle();
      check("rb_b0_ready0", req0_ready_out, 1);
      tick();
      req0_writedata_in = 32'hC000_0001;
      settle();
      check("rb_b1_ready0", req0_ready_out, 1);
      rst = 1'b0;
      settle();
      check("rb_rst_write", mem_write_out, 0);
      check("rb_rst_ready0", req0_ready_out, 0);
      check("rb_rst_addr", mem_address_out, 0);
      check("rb_rst_bcnt", mem_burstcount_out, 0);
      check("rb_rst_err", rd_err_out, 0);
      tick();
      rst = 1'b1;
      req0_write_in = 1'b0;
      req0_read_in = 1'b1; req0_address_in = 32'h900; req0_burstcount_in = 8'd1;
      req1_read_in = 1'b1; req1_address_in = 32'hA00; req1_burstcount_in = 8'd2;
      settle();
      check("rb_idle_ready0", req0_ready_out, 1);
      check("rb_idle_ready1", req1_ready_out, 0);
      check("rb_idle_bcnt", mem_burstcount_out, 1);
      check("rb_idle_addr", mem_address_out, 32'h900);
      sb.push_back('{id: 1'b0, data: 32'hA900_0000});
      tick();
      req0_read_in = 1'b0;
      settle();
      check("rb_next_ready1", req1_ready_out, 1);
      sb.push_back('{id: 1'b1, data: 32'hAA00_0000});
      sb.push_back('{id: 1'b1, data: 32'hAA00_0001});
      tick();
      req1_read_in = 1'b0;
      drain(3);
      check("final_err_clear", rd_err_out, 0);
      check("scoreboard_empty", sb.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
      $finish;
   end

endmodule
